// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter that owns the single write port of the 32x32 register set.
// Two result sources are merged:
//   - ALU pipeline : one result per cycle, never stalls, always wins.
//   - MDU          : ready/valid source; results that cannot be written at once
//                    wait in a small FIFO until a write slot is free.
//
// Handshake (MDU side): a result moves from the MDU into the arbiter on a
// rising CLK edge where mdu_valid && mdu_ready. mdu_ready depends only on the
// registered FIFO count, never on mdu_valid. While mdu_valid is high and
// mdu_ready is low the MDU holds rd/data stable.
//
// Ports:
//   CLK          in   clock, all state updates on the rising edge
//   RES          in   asynchronous active-high reset
//   alu_valid    in   ALU result present this cycle
//   alu_rd       in   [4:0]  ALU destination register
//   alu_data     in   [31:0] ALU result
//   mdu_valid    in   MDU result offered
//   mdu_rd       in   [4:0]  MDU destination register
//   mdu_data     in   [31:0] MDU result
//   mdu_ready    out  arbiter can accept an MDU result this cycle
//   D            out  [31:0] register-set write data (registered)
//   A_D          out  [4:0]  register-set write address (registered)
//   write_enable out  register-set write strobe (registered)
//   pend_mask    out  [31:0] bit i set while a buffered MDU result targets r<i>
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic [31:0] D,
    output logic [4:0]  A_D,
    output logic        write_enable,
    output logic [31:0] pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Circular buffer: valid entries live at slots rd_ptr .. rd_ptr+count-1
    // (modulo DEPTH); the write pointer is rd_ptr+count.
    logic [4:0]    ent_rd   [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [4:0]    nxt_rd   [DEPTH];
    logic [31:0]   nxt_data [DEPTH];
    logic [PW-1:0] nxt_rd_ptr;
    logic [CW-1:0] nxt_count;
    logic [31:0]   nxt_mask;

    logic        alu_wr;
    logic        mdu_xfer;
    logic        fifo_pop;
    logic        bypass;
    logic        push;
    logic        wr_en_nxt;
    logic [4:0]  wr_addr_nxt;
    logic [31:0] wr_data_nxt;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % DEPTH);
    endfunction

    assign mdu_ready = (count < CW'(DEPTH));

    // Source selection. Results for x0 are dropped up front: an ALU rd=0
    // behaves as an idle ALU, an MDU rd=0 still handshakes but goes nowhere.
    always_comb begin
        alu_wr   = alu_valid && (alu_rd != 5'd0);
        mdu_xfer = mdu_valid && mdu_ready;
        fifo_pop = !alu_wr && (count != '0);
        bypass   = !alu_wr && (count == '0) && mdu_xfer && (mdu_rd != 5'd0);
        // A same-cycle ALU write to the same register makes the MDU result stale.
        push     = mdu_xfer && (mdu_rd != 5'd0) && !bypass &&
                   !(alu_wr && (alu_rd == mdu_rd));

        wr_en_nxt   = alu_wr || fifo_pop || bypass;
        wr_addr_nxt = mdu_rd;
        wr_data_nxt = mdu_data;
        if (alu_wr) begin
            wr_addr_nxt = alu_rd;
            wr_data_nxt = alu_data;
        end else if (fifo_pop) begin
            wr_addr_nxt = ent_rd[rd_ptr];
            wr_data_nxt = ent_data[rd_ptr];
        end
    end

    // Next FIFO contents. Surviving entries are compacted in order starting at
    // the new read pointer: the head is skipped when popped, and entries
    // superseded by this cycle's ALU write are squeezed out. Pop and supersede
    // never happen in the same cycle because popping requires an idle ALU.
    always_comb begin : compact_p
        int            j;
        logic [PW-1:0] src;
        logic [PW-1:0] dst;
        logic          keep;

        nxt_rd     = ent_rd;
        nxt_data   = ent_data;
        nxt_mask   = '0;
        nxt_rd_ptr = fifo_pop ? wrap(int'(rd_ptr) + 1) : rd_ptr;
        j          = 0;
        src        = '0;
        dst        = '0;
        keep       = 1'b0;

        for (int k = 0; k < DEPTH; k++) begin
            src  = wrap(int'(rd_ptr) + k);
            keep = (k < int'(count)) &&
                   !(fifo_pop && (k == 0)) &&
                   !(alu_wr && (ent_rd[src] == alu_rd));
            if (keep) begin
                dst                  = wrap(int'(nxt_rd_ptr) + j);
                nxt_rd[dst]          = ent_rd[src];
                nxt_data[dst]        = ent_data[src];
                nxt_mask[ent_rd[src]] = 1'b1;
                j                    = j + 1;
            end
        end

        // mdu_ready guarantees a free slot whenever push is set.
        if (push) begin
            dst              = wrap(int'(nxt_rd_ptr) + j);
            nxt_rd[dst]      = mdu_rd;
            nxt_data[dst]    = mdu_data;
            nxt_mask[mdu_rd] = 1'b1;
            j                = j + 1;
        end

        nxt_count = CW'(j);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            rd_ptr       <= '0;
            count        <= '0;
            pend_mask    <= '0;
            write_enable <= 1'b0;
            A_D          <= '0;
            D            <= '0;
        end else begin
            rd_ptr       <= nxt_rd_ptr;
            count        <= nxt_count;
            pend_mask    <= nxt_mask;
            write_enable <= wr_en_nxt;
            // Address/data hold their last value on idle cycles.
            if (wr_en_nxt) begin
                A_D <= wr_addr_nxt;
                D   <= wr_data_nxt;
            end
        end
    end

    // Payload storage needs no reset: only slots counted by count are ever read.
    always_ff @(posedge CLK) begin
        ent_rd   <= nxt_rd;
        ent_data <= nxt_data;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Bench for wb_arbiter (DEPTH = 2): directed vector table, a mid-cycle reset
// sequence, and randomized traffic compared against a queue-based model of the
// writeback rules.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int NV    = 19;
    localparam int NRAND = 500;

    logic        CLK = 1'b0;
    logic        RES;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [31:0] D;
    logic [4:0]  A_D;
    logic        write_enable;
    logic [31:0] pend_mask;

    int n_chk  = 0;
    int n_pass = 0;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .D            (D),
        .A_D          (A_D),
        .write_enable (write_enable),
        .pend_mask    (pend_mask)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        mdu_valid = mv;
        mdu_rd    = mr;
        mdu_data  = md;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        e_ready;  // sampled before the edge
        logic        e_we;     // after the edge
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs [NV];

    // ---------------- scoreboard / model ----------------
    logic [36:0] exp_q[$];   // {rd, data}, head first
    logic        m_we;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    logic [31:0] m_mask;
    logic        m_ready;

    // One cycle of the writeback rules on the model queue.
    task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md);
        logic        xfer;
        logic [36:0] h;
        m_ready = (exp_q.size() < DEPTH);
        xfer    = mv && m_ready;
        m_we    = 1'b0;
        if (av && ar != 5'd0) begin
            m_we = 1'b1; m_a = ar; m_d = ad;
            for (int k = exp_q.size() - 1; k >= 0; k--)
                if (exp_q[k][36:32] == ar) exp_q.delete(k);
            if (xfer && mr != 5'd0 && mr != ar) exp_q.push_back({mr, md});
        end else if (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            m_we = 1'b1; m_a = h[36:32]; m_d = h[31:0];
            if (xfer && mr != 5'd0) exp_q.push_back({mr, md});
        end else if (xfer && mr != 5'd0) begin
            m_we = 1'b1; m_a = mr; m_d = md;
        end
        m_mask = '0;
        foreach (exp_q[k]) m_mask[exp_q[k][36:32]] = 1'b1;
    endtask

    initial begin
        // av ar  ad            mv mr  md            rdy we a   d             mask
        vecs[0]  = '{1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  32'h30,     1'b1, 1'b1, 5'd5,  32'h30,   32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd5,  32'h30,   32'h0};
        vecs[2]  = '{1'b1, 5'd1,  32'h101,   1'b1, 5'd7,  32'h77,     1'b1, 1'b1, 5'd1,  32'h101,  32'h80};
        vecs[3]  = '{1'b1, 5'd2,  32'h102,   1'b1, 5'd8,  32'h88,     1'b1, 1'b1, 5'd2,  32'h102,  32'h180};
        vecs[4]  = '{1'b1, 5'd3,  32'h103,   1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 5'd3,  32'h103,  32'h180};
        vecs[5]  = '{1'b1, 5'd4,  32'h104,   1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 5'd4,  32'h104,  32'h180};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b0, 1'b1, 5'd7,  32'h77,   32'h100};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 5'd8,  32'h88,   32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd8,  32'h88,   32'h0};
        vecs[9]  = '{1'b1, 5'd10, 32'h1010,  1'b1, 5'd9,  32'hAAAA,   1'b1, 1'b1, 5'd10, 32'h1010, 32'h200};
        vecs[10] = '{1'b1, 5'd9,  32'h1234,  1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 5'd9,  32'h1234, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd9,  32'h1234, 32'h0};
        vecs[12] = '{1'b1, 5'd3,  32'h11,    1'b1, 5'd3,  32'h22,     1'b1, 1'b1, 5'd3,  32'h11,   32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd3,  32'h11,   32'h0};
        vecs[14] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd3,  32'h11,   32'h0};
        vecs[16] = '{1'b1, 5'd12, 32'hC,     1'b1, 5'd13, 32'hD,      1'b1, 1'b1, 5'd12, 32'hC,    32'h2000};
        vecs[17] = '{1'b1, 5'd0,  32'hEE,    1'b1, 5'd0,  32'hEF,     1'b1, 1'b1, 5'd13, 32'hD,    32'h0};
        vecs[18] = '{1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd13, 32'hD,    32'h0};
    end

    // ---------------- test sequence ----------------
    initial begin
        logic        av, mv, hold;
        logic [4:0]  ar, mr;
        logic [31:0] ad, md;

        RES = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we",   {31'h0, write_enable}, 32'h0);
        chk("rst_a",    {27'h0, A_D}, 32'h0);
        chk("rst_d",    D, 32'h0);
        chk("rst_mask", pend_mask, 32'h0);
        RES = 1'b0;
        #1;
        chk("rst_ready", {31'h0, mdu_ready}, 32'h1);

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
            #1;
            chk($sformatf("v%0d_ready", i), {31'h0, mdu_ready}, {31'h0, vecs[i].e_ready});
            tick();
            chk($sformatf("v%0d_we", i),   {31'h0, write_enable}, {31'h0, vecs[i].e_we});
            chk($sformatf("v%0d_a", i),    {27'h0, A_D}, {27'h0, vecs[i].e_a});
            chk($sformatf("v%0d_d", i),    D, vecs[i].e_d);
            chk($sformatf("v%0d_mask", i), pend_mask, vecs[i].e_mask);
        end

        // Mid-cycle reset with two buffered MDU results.
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        tick();
        drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
        tick();
        chk("pre_rst_mask", pend_mask, 32'h00A0_0000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        RES = 1'b1;
        #1;
        chk("arst_we",   {31'h0, write_enable}, 32'h0);
        chk("arst_a",    {27'h0, A_D}, 32'h0);
        chk("arst_d",    D, 32'h0);
        chk("arst_mask", pend_mask, 32'h0);
        @(posedge CLK);
        #1;
        RES = 1'b0;
        #1;
        chk("arst_ready", {31'h0, mdu_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_stale_we", {31'h0, write_enable}, 32'h0);
            chk("arst_no_stale_mask", pend_mask, 32'h0);
        end

        // Randomized traffic against the model. The MDU holds an offer until
        // the model says it was accepted.
        exp_q.delete();
        m_a = '0;
        m_d = '0;
        hold = 1'b0;
        mv = 1'b0; mr = '0; md = '0;
        for (int c = 0; c < NRAND + 8; c++) begin
            if (c < NRAND) begin
                av = ($urandom_range(0, 99) < 50);
                ar = 5'($urandom_range(0, 7));
                ad = $urandom;
                if (!hold) begin
                    mv = ($urandom_range(0, 99) < 60);
                    mr = 5'($urandom_range(0, 7));
                    md = $urandom;
                end
            end else begin
                av = 1'b0; ar = '0; ad = '0;
                if (!hold) begin mv = 1'b0; mr = '0; md = '0; end
            end
            drive(av, ar, ad, mv, mr, md);
            model_step(av, ar, ad, mv, mr, md);
            hold = mv && !m_ready;
            #1;
            chk("rnd_ready", {31'h0, mdu_ready}, {31'h0, m_ready});
            tick();
            chk("rnd_we",   {31'h0, write_enable}, {31'h0, m_we});
            chk("rnd_a",    {27'h0, A_D}, {27'h0, m_a});
            chk("rnd_d",    D, m_d);
            chk("rnd_mask", pend_mask, m_mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that drives the single write port of the 32x32 register set (D, A_D, write_enable).
- Merges two result sources:
  - ALU pipeline: single-cycle, can never stall, always has priority.
  - Multicycle multiply/divide unit (MDU): ready/valid handshake, results held in a small FIFO until a free write slot.
- Exports a pending-write mask so issue logic can detect hazards on buffered MDU results.

Parameters:
- DEPTH, 2, MDU result FIFO entries (1..4).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RES  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mdu_valid  in  1  MDU result offered.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  arbiter accepts MDU result this cycle.
- D  out  32  register-set write data (registered).
- A_D  out  5  register-set write address (registered).
- write_enable  out  1  register-set write strobe (registered).
- pend_mask  out  32  bit i = 1 while a valid FIFO entry targets register i.

Behaviour:
- Reset (RES=1, asynchronous):
  - D, A_D, write_enable, pend_mask = 0; FIFO emptied.
  - mdu_ready = 1 once RES deasserts.
  - Reset mid-operation discards all buffered results, with no write issued.
- Outputs are registered: a selected result appears on D/A_D/write_enable one cycle after its input cycle.
- MDU handshake:
  - mdu_ready = (count < DEPTH), combinational from the registered count only.
  - Transfer occurs when mdu_valid && mdu_ready.
  - mdu_valid with mdu_ready=0: nothing accepted; source holds its data.
- Register x0: any result with rd=0 is dropped.
  - ALU: cycle treated as alu_valid=0.
  - MDU: still handshaken (accepted, mdu_ready behaviour unchanged), never enqueued, never written.
- Per-cycle selection (priority order):
  1. alu_valid (rd≠0): write ALU result. An MDU transfer this cycle is enqueued at the tail.
  2. Otherwise, FIFO non-empty: write FIFO head and pop it. An MDU transfer this cycle is enqueued.
  3. Otherwise, MDU transfer this cycle: bypass straight to the output, not enqueued.
  4. Otherwise: write_enable=0; D/A_D hold their previous values.
- Ordering / supersede:
  - An ALU write to rd invalidates every valid FIFO entry with the same rd. Invalidated entries are removed without a write and pend_mask updates.
  - Simultaneous ALU and MDU transfer with the same rd: MDU result discarded (not enqueued), ALU written.
- FIFO:
  - Circular with wrap-around read/write pointers and a count register.
  - Push and pop in the same cycle when full is legal only via the pop path; mdu_ready is already 0 when full, so no overflow is possible.
  - Invalidation compacts entries or marks them invalid; in both cases count reflects valid entries only.
- pend_mask:
  - Registered; reflects FIFO contents after the current edge.
  - Bits for entries popped or invalidated clear on the same edge.
  - A bypassed result never sets pend_mask.
- Write throughput: at most one write per cycle; no result is lost except by the x0 drop and supersede rules above.

Test Plan:
- Reset: assert RES asynchronously mid-cycle with 2 entries buffered → write_enable, D, A_D, pend_mask = 0 immediately; after release mdu_ready=1 and no stale write ever appears.
- Bypass: ALU idle, MDU offers rd=5, data=0x0000_0030 → next cycle write_enable=1, A_D=5, D=0x30; pend_mask stays 0.
- Contention: ALU writes rd=1..4 on 4 consecutive cycles while MDU offers rd=7 (0x77) then rd=8 (0x88):
  - both accepted; mdu_ready=0 after the second, with pend_mask bits 7,8 set;
  - after the ALU goes idle, writes 7 then 8 appear in order and pend_mask returns to 0.
- Supersede: rd=9 buffered (0xAAAA), then ALU writes rd=9 = 0x1234 → single write 9=0x1234; the buffered entry is never written and pend_mask[9] clears.
- Same-cycle same rd: ALU and MDU both target rd=3 (0x11 / 0x22), FIFO empty → one write 3=0x11; FIFO remains empty.
- x0: ALU rd=0 and MDU rd=0 with data 0xFFFF_FFFF → write_enable stays 0, MDU handshake completes, pend_mask unchanged.
